// File: rtl/md_unit_pkg.sv
// md_unit_pkg: shared mdOp encoding for the decoder and the multiply/divide unit.
// Contents: md_op_e enum (NOT_MD..MFLO) and is_md(), which treats codes 9..15 as NOT_MD.
package md_unit_pkg;
  typedef enum logic [3:0] {
    NOT_MD = 4'd0,
    MULT   = 4'd1,
    MULTU  = 4'd2,
    DIV    = 4'd3,
    DIVU   = 4'd4,
    MTHI   = 4'd5,
    MTLO   = 4'd6,
    MFHI   = 4'd7,
    MFLO   = 4'd8
  } md_op_e;

  function automatic logic is_md(input logic [3:0] op);
    return op inside {[4'd1:4'd8]};
  endfunction
endpackage

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning HI/LO, with multi-cycle latency and a stall term.
// Ports: clk; reset (async, active-low); mdOpE/mdOpD (mdOp in E and D); srcA/srcB (operands in E);
//        start (E op begins this cycle); busy (op in flight); hiLoOut (HI/LO for mfhi/mflo, else 0);
//        mdStall (hold a D-stage MD instruction while the unit is starting or busy).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  mdOpE,
  input  logic [3:0]  mdOpD,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic        start,
  output logic        busy,
  output logic [31:0] hiLoOut,
  output logic        mdStall
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [31:0] hi, lo, pend_hi, pend_lo;
  logic        pend_valid;
  logic [CW-1:0] cnt;
  logic        is_mul, div_zero;
  logic [63:0] sprod, uprod, res;
  logic signed [31:0] sa, sb;
  logic [31:0] squo, srem, udvs, uquo, urem;
  assign start   = (mdOpE inside {MULT, MULTU, DIV, DIVU}) & ~busy;
  assign mdStall = is_md(mdOpD) & (start | busy);
  assign hiLoOut = mdOpE == MFHI ? hi : mdOpE == MFLO ? lo : 32'd0;
  assign is_mul   = mdOpE == MULT || mdOpE == MULTU;
  assign div_zero = srcB == 32'd0;
  // Sign-extended operands give the signed product in the low 64 bits.
  assign sprod = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
  assign uprod = {32'd0, srcA} * {32'd0, srcB};
  // A zero divisor is replaced by 1 only to keep the divider X-free; its result is never committed.
  assign sa   = $signed(srcA);
  assign sb   = div_zero ? 32'sd1 : $signed(srcB);
  assign squo = sa / sb;
  assign srem = sa % sb;
  assign udvs = div_zero ? 32'd1 : srcB;
  assign uquo = srcA / udvs;
  assign urem = srcA % udvs;
  assign res  = mdOpE == MULT ? sprod : mdOpE == MULTU ? uprod :
                mdOpE == DIV  ? {srem, squo} : {urem, uquo};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi         <= '0;
      lo         <= '0;
      pend_hi    <= '0;
      pend_lo    <= '0;
      pend_valid <= 1'b0;
      cnt        <= '0;
      busy       <= 1'b0;
    end else if (start) begin
      pend_hi    <= res[63:32];
      pend_lo    <= res[31:0];
      pend_valid <= is_mul | ~div_zero;
      cnt        <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      busy       <= 1'b1;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        if (pend_valid) begin
          hi <= pend_hi;
          lo <= pend_lo;
        end
      end
    end else if (mdOpE == MTHI) begin
      hi <= srcA;
    end else if (mdOpE == MTLO) begin
      lo <= srcA;
    end
  end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit; stimulus queues expected reads, busy lengths and stall lengths.
module tb_md_unit;
  import md_unit_pkg::*;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  mdOpE = 4'd0;
  logic [3:0]  mdOpD = 4'd0;
  logic [31:0] srcA = '0;
  logic [31:0] srcB = '0;
  logic        start, busy, mdStall;
  logic [31:0] hiLoOut;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    string       name;
    logic [31:0] v;
  } exp_t;
  exp_t rd_q[$];
  int   busy_q[$];
  int   stall_q[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .mdOpE(mdOpE), .mdOpD(mdOpD), .srcA(srcA), .srcB(srcB),
    .start(start), .busy(busy), .hiLoOut(hiLoOut), .mdStall(mdStall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares on the falling edge whenever the DUT presents a read or ends a busy/stall run.
  initial begin
    int brun = 0;
    int srun = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        brun = 0;
        srun = 0;
      end else begin
        if (mdOpE == MFHI || mdOpE == MFLO) begin
          if (rd_q.size() == 0) chk("unexpected_read", hiLoOut, 32'hxxxxxxxx);
          else begin
            e = rd_q.pop_front();
            chk(e.name, hiLoOut, e.v);
          end
        end
        if (busy) brun++;
        else if (brun > 0) begin
          if (busy_q.size() == 0) chk("unexpected_busy_run", brun, 0);
          else chk("busy_cycles", brun, busy_q.pop_front());
          brun = 0;
        end
        if (mdStall) srun++;
        else if (srun > 0) begin
          if (stall_q.size() == 0) chk("unexpected_stall_run", srun, 0);
          else chk("stall_cycles", srun, stall_q.pop_front());
          srun = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [3:0] op, input logic [31:0] v, input string name);
    rd_q.push_back('{name, v});
    mdOpE = op;
    step();
    mdOpE = NOT_MD;
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] a);
    mdOpE = op;
    srcA = a;
    step();
    mdOpE = NOT_MD;
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy && k < 40) begin
      step();
      k++;
    end
    if (busy) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int n, input string name);
    busy_q.push_back(n);
    mdOpE = op;
    srcA = a;
    srcB = b;
    #1 chk({name, "_start"}, start, 1'b1);
    step();
    mdOpE = NOT_MD;
    srcA = 32'hdeadbeef;
    srcB = 32'h0badf00d;
    wait_idle(name);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 1'b0);
    reset = 1'b1;
    step();
    rd(MFLO, 32'h0, "reset_lo");
    rd(MFHI, 32'h0, "reset_hi");
    mt(MTHI, 32'h1234);
    rd(MFHI, 32'h1234, "mthi");
    rd(MFLO, 32'h0, "mflo_zero");
    run_op(MULT, 32'hFFFFFFFF, 32'd2, 5, "mult");
    rd(MFHI, 32'hFFFFFFFF, "mult_hi");
    rd(MFLO, 32'hFFFFFFFE, "mult_lo");
    run_op(MULTU, 32'hFFFFFFFF, 32'd2, 5, "multu");
    rd(MFHI, 32'h00000001, "multu_hi");
    rd(MFLO, 32'hFFFFFFFE, "multu_lo");
    run_op(DIV, 32'hFFFFFFF9, 32'd2, 10, "div");
    rd(MFLO, 32'hFFFFFFFD, "div_lo");
    rd(MFHI, 32'hFFFFFFFF, "div_hi");
    run_op(DIVU, 32'd7, 32'd2, 10, "divu");
    rd(MFLO, 32'd3, "divu_lo");
    rd(MFHI, 32'd1, "divu_hi");
    mt(MTHI, 32'hA);
    mt(MTLO, 32'hB);
    run_op(DIVU, 32'd99, 32'd0, 10, "divz");
    rd(MFHI, 32'hA, "divz_hi");
    rd(MFLO, 32'hB, "divz_lo");
    // MULT in E with MFLO behind it in D: D holds through the last busy cycle, then MFLO moves to E.
    busy_q.push_back(5);
    stall_q.push_back(6);
    mdOpE = MULT;
    mdOpD = MFLO;
    srcA = 32'd3;
    srcB = 32'd5;
    step();
    mdOpE = NOT_MD;
    repeat (5) step();
    mdOpD = NOT_MD;
    rd(MFLO, 32'd15, "stall_mflo");
    // Reset in the middle of a divide: state clears at once and the pending result never lands.
    mt(MTHI, 32'h12);
    mdOpE = DIVU;
    srcA = 32'd100;
    srcB = 32'd3;
    step();
    mdOpE = NOT_MD;
    repeat (4) step();
    #2 reset = 1'b0;
    #1 chk("rst_busy", busy, 1'b0);
    mdOpE = MFHI;
    #1 chk("rst_hi_async", hiLoOut, 32'h0);
    mdOpE = NOT_MD;
    step();
    reset = 1'b1;
    repeat (12) step();
    chk("rst_no_restart", busy, 1'b0);
    rd(MFHI, 32'h0, "rst_hi_after");
    rd(MFLO, 32'h0, "rst_lo_after");
    repeat (2) step();
    chk("rd_q_drained", rd_q.size(), 0);
    chk("busy_q_drained", busy_q.size(), 0);
    chk("stall_q_drained", stall_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
